// File: rtl/sort_result_collector.sv
// sort_result_collector
// Receiving end of the sorter's serial output stream. Captures one frame of N
// signed words into a local bank, checks the ordering of the stream as it
// arrives, and exposes the captured frame through a registered read port.
// Reset is synchronous and active-low; clear_i re-arms for the next frame
// without touching the bank contents.
module sort_result_collector #(
  parameter int WIDTH      = 32,
  parameter int N          = 8,
  parameter int ADDR_W     = 3,
  parameter bit DESCENDING = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [WIDTH-1:0]  data_serial_i,
  input  logic                     data_valid_i,
  input  logic                     clear_i,
  input  logic        [ADDR_W-1:0] rd_addr_i,
  output logic signed [WIDTH-1:0]  rd_data_o,
  output logic        [ADDR_W:0]   count_o,
  output logic                     done_o,
  output logic                     order_err_o,
  output logic                     overflow_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Count value of the last word of a frame; capturing it completes the frame.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N - 1);

  state_t                    state_q, state_d;
  logic        [ADDR_W:0]    count_q, count_d;
  logic signed [WIDTH-1:0]   prev_q, prev_d;
  logic                      done_q, done_d;
  logic                      order_err_q, order_err_d;
  logic                      overflow_q, overflow_d;
  logic signed [WIDTH-1:0]   bank_q [N];
  logic signed [WIDTH-1:0]   rd_data_q;
  logic signed [WIDTH-1:0]   rd_mux;
  logic                      wr_en;
  logic        [ADDR_W-1:0]  wr_idx;
  logic                      violation;

  // Ordering check of the incoming word against the previously captured one.
  always_comb begin
    violation = 1'b0;
    if (DESCENDING) begin
      violation = (data_serial_i > prev_q);
    end else begin
      violation = (data_serial_i < prev_q);
    end
  end

  // Next-state logic: frame FSM, word counter, flags and bank write request.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    prev_d      = prev_q;
    done_d      = done_q;
    order_err_d = order_err_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    if (clear_i) begin
      state_d     = IDLE;
      count_d     = '0;
      done_d      = 1'b0;
      order_err_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (data_valid_i) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            prev_d  = data_serial_i;
            count_d = (ADDR_W+1)'(1);
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (data_valid_i) begin
            wr_en   = 1'b1;
            wr_idx  = count_q[ADDR_W-1:0];
            prev_d  = data_serial_i;
            count_d = count_q + 1'b1;
            if (violation) begin
              order_err_d = 1'b1;
            end
            if (count_q == LAST_IDX) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          if (data_valid_i) begin
            overflow_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      prev_q      <= '0;
      done_q      <= 1'b0;
      order_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prev_q      <= prev_d;
      done_q      <= done_d;
      order_err_q <= order_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // Capture bank: one entry written per accepted word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en && (wr_idx == i[ADDR_W-1:0])) begin
          bank_q[i] <= data_serial_i;
        end
      end
    end
  end

  // Read select; addresses past the frame length return zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_addr_i == i[ADDR_W-1:0]) begin
        rd_mux = bank_q[i];
      end
    end
  end

  // Registered read port; samples the bank before this edge's write lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_mux;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign count_o     = count_q;
  assign done_o      = done_q;
  assign order_err_o = order_err_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_sort_result_collector.sv
// tb_sort_result_collector
// Directed self-checking bench for sort_result_collector (N=8, ADDR_W=4,
// ascending order). Expected values are hand-computed constants.
module tb_sort_result_collector;

  localparam int WIDTH  = 32;
  localparam int N      = 8;
  localparam int ADDR_W = 4;

  logic                     clk;
  logic                     rst;
  logic signed [WIDTH-1:0]  dataSerial;
  logic                     dataValid;
  logic                     clearReq;
  logic        [ADDR_W-1:0] rdAddr;
  logic signed [WIDTH-1:0]  rdData;
  logic        [ADDR_W:0]   countOut;
  logic                     doneOut;
  logic                     orderErr;
  logic                     overflowOut;

  int checks;
  int failures;

  logic signed [WIDTH-1:0] streamT1 [N];
  logic signed [WIDTH-1:0] streamT2 [N];

  sort_result_collector #(
    .WIDTH(WIDTH),
    .N(N),
    .ADDR_W(ADDR_W),
    .DESCENDING(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_serial_i(dataSerial),
    .data_valid_i(dataValid),
    .clear_i(clearReq),
    .rd_addr_i(rdAddr),
    .rd_data_o(rdData),
    .count_o(countOut),
    .done_o(doneOut),
    .order_err_o(orderErr),
    .overflow_o(overflowOut)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then settle 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic signed [WIDTH-1:0] d,
                               input logic c, input logic [ADDR_W-1:0] a);
    dataValid  = v;
    dataSerial = d;
    clearReq   = c;
    rdAddr     = a;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence T1..T6.
  initial begin
    int gap;
    checks   = 0;
    failures = 0;
    streamT1 = '{-5, -1, 0, 0, 3, 7, 100, 32'sh7FFFFFFF};
    streamT2 = '{1, 2, 9, 4, 5, 6, 7, 8};

    rst        = 1'b0;
    dataValid  = 1'b0;
    dataSerial = '0;
    clearReq   = 1'b0;
    rdAddr     = '0;
    applyStimulus(1'b0, 0, 1'b0, 0);
    applyStimulus(1'b1, 99, 1'b0, 0);
    checkOutput("reset_count", countOut, 0);
    checkOutput("reset_done", doneOut, 0);
    checkOutput("reset_err", orderErr, 0);
    checkOutput("reset_ovf", overflowOut, 0);
    checkOutput("reset_rd", rdData, 0);
    rst = 1'b1;

    // T1: ordered stream with duplicates and the largest positive value.
    $display("[TB] T1 ordered stream");
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b1, streamT1[k], 1'b0, 0);
      checkOutput($sformatf("t1_count%0d", k), countOut, k + 1);
      checkOutput($sformatf("t1_done%0d", k), doneOut, (k == N - 1) ? 1 : 0);
    end
    checkOutput("t1_err", orderErr, 0);
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b0, 0, 1'b0, ADDR_W'(k));
      checkOutput($sformatf("t1_rd%0d", k), rdData, 64'(streamT1[k]));
    end

    // T4: extra words while done are dropped and flag overflow.
    $display("[TB] T4 overflow and clear");
    applyStimulus(1'b1, 11, 1'b0, 0);
    checkOutput("t4_ovf1", overflowOut, 1);
    applyStimulus(1'b1, 12, 1'b0, 0);
    checkOutput("t4_rd0", rdData, 64'(streamT1[0]));
    checkOutput("t4_count", countOut, 8);
    checkOutput("t4_done", doneOut, 1);
    applyStimulus(1'b0, 0, 1'b0, 1);
    checkOutput("t4_rd1", rdData, 64'(streamT1[1]));
    applyStimulus(1'b0, 0, 1'b1, 7);
    checkOutput("t4_clr_count", countOut, 0);
    checkOutput("t4_clr_done", doneOut, 0);
    checkOutput("t4_clr_ovf", overflowOut, 0);
    checkOutput("t4_clr_err", orderErr, 0);
    checkOutput("t4_retained", rdData, 64'(streamT1[7]));

    // T2: out-of-order word 4 after 9 raises a sticky order error.
    $display("[TB] T2 ordering violation");
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b1, streamT2[k], 1'b0, 0);
      checkOutput($sformatf("t2_err%0d", k), orderErr, (k >= 3) ? 1 : 0);
    end
    checkOutput("t2_done", doneOut, 1);
    applyStimulus(1'b0, 0, 1'b1, 0);
    checkOutput("t2_clr_err", orderErr, 0);

    // T3: T1 stream with random idle gaps between words.
    $display("[TB] T3 gapped stream");
    for (int k = 0; k < N; k++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 32'sh0BAD, 1'b0, 0);
        checkOutput($sformatf("t3_gap%0d", k), countOut, k);
      end
      applyStimulus(1'b1, streamT1[k], 1'b0, 0);
      checkOutput($sformatf("t3_count%0d", k), countOut, k + 1);
    end
    checkOutput("t3_done", doneOut, 1);
    checkOutput("t3_err", orderErr, 0);
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b0, 0, 1'b0, ADDR_W'(k));
      checkOutput($sformatf("t3_rd%0d", k), rdData, 64'(streamT1[k]));
    end
    applyStimulus(1'b0, 0, 1'b1, 0);

    // T5: reset mid-frame wipes the bank and all outputs.
    $display("[TB] T5 mid-frame reset");
    applyStimulus(1'b1, 10, 1'b0, 0);
    applyStimulus(1'b1, 20, 1'b0, 0);
    applyStimulus(1'b1, 5, 1'b0, 0);
    applyStimulus(1'b1, 40, 1'b0, 0);
    checkOutput("t5_pre_err", orderErr, 1);
    checkOutput("t5_pre_count", countOut, 4);
    rst = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 0);
    rst = 1'b1;
    checkOutput("t5_count", countOut, 0);
    checkOutput("t5_err", orderErr, 0);
    checkOutput("t5_done", doneOut, 0);
    checkOutput("t5_rd", rdData, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 0, 1'b0, ADDR_W'(k));
      checkOutput($sformatf("t5_rd%0d", k), rdData, 0);
    end
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b1, k + 1, 1'b0, 0);
    end
    checkOutput("t5_new_done", doneOut, 1);
    checkOutput("t5_new_count", countOut, 8);
    applyStimulus(1'b0, 0, 1'b0, 5);
    checkOutput("t5_new_rd5", rdData, 6);

    // T6: clear together with a valid word drops the word.
    $display("[TB] T6 clear versus valid, out-of-range read");
    applyStimulus(1'b0, 0, 1'b1, 0);
    applyStimulus(1'b1, 100, 1'b0, 0);
    applyStimulus(1'b1, 200, 1'b0, 0);
    applyStimulus(1'b1, 300, 1'b0, 0);
    checkOutput("t6_pre_count", countOut, 3);
    applyStimulus(1'b1, 55, 1'b1, 0);
    checkOutput("t6_count", countOut, 0);
    checkOutput("t6_done", doneOut, 0);
    applyStimulus(1'b0, 0, 1'b0, 3);
    checkOutput("t6_not_stored", rdData, 4);
    applyStimulus(1'b0, 0, 1'b0, 9);
    checkOutput("t6_rd_oob", rdData, 0);
    // Read-during-write on entry 0 returns the old value, then the new one.
    applyStimulus(1'b1, 77, 1'b0, 0);
    checkOutput("t6_rdw_old", rdData, 100);
    checkOutput("t6_rdw_count", countOut, 1);
    applyStimulus(1'b0, 0, 1'b0, 0);
    checkOutput("t6_rdw_new", rdData, 77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=stalled expected=finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
